// File: rtl/vec_pkg.sv
// Shared types and encodings for the vector-coprocessor command controller.
// Holds op-code/state enums, bus_sel encodings and the command decode helpers.
package vec_pkg;

  localparam int VLEN_MAX_DEF = 32;
  localparam int VLEN_W       = 6;
  localparam int CNT_W        = 6;

  typedef enum logic [2:0] {
    OP_CONFIG  = 3'd0,
    OP_ALU     = 3'd1,
    OP_MUL     = 3'd2,
    OP_ACC     = 3'd3,
    OP_ILLEGAL = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB   = 3'd3,
    ST_RSP  = 3'd4
  } state_e;

  localparam logic [1:0] BUS_NONE = 2'b00;
  localparam logic [1:0] BUS_ALU  = 2'b01;
  localparam logic [1:0] BUS_MUL  = 2'b10;
  localparam logic [1:0] BUS_ACC  = 2'b11;

  typedef struct packed {
    op_e        op;
    logic [4:0] src0;
    logic [4:0] src1;
    logic [4:0] dst;
    logic [7:0] imm;
    logic [1:0] alu_mode;
    logic       alu_op1_sel;
  } cmd_t;

  function automatic op_e decode_op(input logic [2:0] code);
    op_e op;
    case (code)
      3'd0:    op = OP_CONFIG;
      3'd1:    op = OP_ALU;
      3'd2:    op = OP_MUL;
      3'd3:    op = OP_ACC;
      default: op = OP_ILLEGAL;
    endcase
    return op;
  endfunction

  function automatic cmd_t decode_cmd(input logic [5:0]  fid,
                                      input logic [14:0] in0,
                                      input logic [7:0]  in1);
    cmd_t c;
    c.op          = decode_op(fid[2:0]);
    c.alu_mode    = fid[4:3];
    c.alu_op1_sel = fid[5];
    c.src0        = in0[4:0];
    c.src1        = in0[9:5];
    c.dst         = in0[14:10];
    c.imm         = in1;
    return c;
  endfunction

  function automatic logic [1:0] bus_for_op(input op_e op);
    logic [1:0] sel;
    case (op)
      OP_ALU:  sel = BUS_ALU;
      OP_MUL:  sel = BUS_MUL;
      OP_ACC:  sel = BUS_ACC;
      default: sel = BUS_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/vec_beat_counter.sv
// Down-counter that times the EXEC phase: load a beat count, decrement once per
// beat, and flag the final beat.
module vec_beat_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  // A count of 0 also reads as done so a zero load can never stall EXEC.
  assign o_done  = (r_count[W-1:1] == '0);
  assign o_count = r_count;

endmodule

// File: rtl/vec_ctrl.sv
// Command controller for a CPU-attached vector unit: accepts one command at a
// time, sequences register-file/datapath control and returns a single response.
module vec_ctrl
  import vec_pkg::*;
#(
  parameter int MUL_LAT  = 2,
  parameter int VLEN_MAX = VLEN_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0,
  output logic [4:0]  reg_op0_sel,
  output logic [4:0]  reg_op1_sel,
  output logic [4:0]  reg_wb_sel,
  output logic        wb_load,
  output logic [1:0]  bus_sel,
  output logic [1:0]  alu_mode,
  output logic        alu_op1_sel,
  output logic [7:0]  alu_imm,
  output logic [2:0]  vlmul,
  output logic [5:0]  vlen,
  output logic        acc_en,
  input  logic [7:0]  acc_out,
  output logic        busy
);

  localparam logic [VLEN_W-1:0] LP_VLEN_MAX = VLEN_W'(VLEN_MAX);
  localparam logic [CNT_W-1:0]  LP_MUL_LAT  = CNT_W'(MUL_LAT);

  state_e              r_state;
  state_e              w_state_next;
  cmd_t                r_cmd;
  cmd_t                w_cmd_in;
  logic [VLEN_W-1:0]   r_vlen;
  logic [2:0]          r_vlmul;
  logic [31:0]         r_rsp_data;
  logic [VLEN_W-1:0]   w_vlen_req;
  logic [VLEN_W-1:0]   w_vlen_grant;
  logic                w_accept;
  logic                w_cnt_load;
  logic                w_cnt_dec;
  logic                w_cnt_done;
  logic [CNT_W-1:0]    w_cnt_value;
  logic [CNT_W-1:0]    w_exec_len;
  logic                w_unused;

  assign w_cmd_in = decode_cmd(cmd_payload_function_id[5:0],
                               cmd_payload_inputs_0[14:0],
                               cmd_payload_inputs_1[7:0]);
  assign w_accept = cmd_valid && cmd_ready;

  assign w_vlen_req   = cmd_payload_inputs_0[VLEN_W-1:0];
  assign w_vlen_grant = (w_vlen_req > LP_VLEN_MAX) ? LP_VLEN_MAX : w_vlen_req;

  assign w_unused = &{1'b0, cmd_payload_function_id[9:6], cmd_payload_inputs_0[31:15],
                      cmd_payload_inputs_1[31:8], w_cnt_value};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    busy         = 1'b1;
    wb_load      = 1'b0;
    bus_sel      = BUS_NONE;
    reg_wb_sel   = '0;
    acc_en       = 1'b0;
    rsp_valid    = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          // CONFIG and ILLEGAL have nothing to execute and answer directly.
          if ((w_cmd_in.op == OP_CONFIG) || (w_cmd_in.op == OP_ILLEGAL)) begin
            w_state_next = ST_RSP;
          end else begin
            w_state_next = ST_READ;
          end
        end
      end
      ST_READ: begin
        w_cnt_load   = 1'b1;
        w_state_next = ST_EXEC;
      end
      ST_EXEC: begin
        w_cnt_dec = 1'b1;
        acc_en    = (r_cmd.op == OP_ACC);
        if (w_cnt_done) begin
          w_state_next = ST_WB;
        end
      end
      ST_WB: begin
        wb_load      = 1'b1;
        reg_wb_sel   = r_cmd.dst;
        bus_sel      = bus_for_op(r_cmd.op);
        w_state_next = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ACC runs one beat per vector element, with a floor of one beat.
  always_comb begin
    w_exec_len = CNT_W'(1);
    case (r_cmd.op)
      OP_MUL:  w_exec_len = LP_MUL_LAT;
      OP_ACC:  w_exec_len = (r_vlen == '0) ? CNT_W'(1) : CNT_W'(r_vlen);
      default: w_exec_len = CNT_W'(1);
    endcase
  end

  vec_beat_counter #(
    .W (CNT_W)
  ) u_beat_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_exec_len),
    .i_dec      (w_cnt_dec),
    .o_count    (w_cnt_value),
    .o_done     (w_cnt_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd      <= '0;
      r_vlen     <= LP_VLEN_MAX;
      r_vlmul    <= '0;
      r_rsp_data <= '0;
    end else begin
      if (w_accept) begin
        r_cmd <= w_cmd_in;
        if (w_cmd_in.op == OP_CONFIG) begin
          r_vlen     <= w_vlen_grant;
          r_vlmul    <= cmd_payload_inputs_1[2:0];
          r_rsp_data <= {{(32-VLEN_W){1'b0}}, w_vlen_grant};
        end else if (w_cmd_in.op == OP_ILLEGAL) begin
          r_rsp_data <= '1;
        end
      end
      // The accumulator result is captured on the writeback beat and then frozen.
      if (r_state == ST_WB) begin
        r_rsp_data <= (r_cmd.op == OP_ACC) ? {24'b0, acc_out} : 32'b0;
      end
    end
  end

  assign rsp_payload_outputs_0 = r_rsp_data;
  assign reg_op0_sel           = r_cmd.src0;
  assign reg_op1_sel           = r_cmd.src1;
  assign alu_mode              = r_cmd.alu_mode;
  assign alu_op1_sel           = r_cmd.alu_op1_sel;
  assign alu_imm               = r_cmd.imm;
  assign vlen                  = r_vlen;
  assign vlmul                 = r_vlmul;

endmodule

// File: tb/tb_vec_ctrl.sv
// Randomized self-checking bench for vec_ctrl against a cycle-phase reference model.
module tb_vec_ctrl;

  localparam int MUL_LAT  = 3;
  localparam int VLEN_MAX = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id = '0;
  logic [31:0] cmd_payload_inputs_0 = '0;
  logic [31:0] cmd_payload_inputs_1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_payload_outputs_0;
  logic [4:0]  reg_op0_sel, reg_op1_sel, reg_wb_sel;
  logic        wb_load;
  logic [1:0]  bus_sel, alu_mode;
  logic        alu_op1_sel;
  logic [7:0]  alu_imm;
  logic [2:0]  vlmul;
  logic [5:0]  vlen;
  logic        acc_en;
  logic [7:0]  acc_out = '0;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int m_vlen   = VLEN_MAX;
  int m_vlmul  = 0;
  int txn_id   = 0;

  always #5 clk = ~clk;

  vec_ctrl #(.MUL_LAT(MUL_LAT), .VLEN_MAX(VLEN_MAX)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0),
    .reg_op0_sel             (reg_op0_sel),
    .reg_op1_sel             (reg_op1_sel),
    .reg_wb_sel              (reg_wb_sel),
    .wb_load                 (wb_load),
    .bus_sel                 (bus_sel),
    .alu_mode                (alu_mode),
    .alu_op1_sel             (alu_op1_sel),
    .alu_imm                 (alu_imm),
    .vlmul                   (vlmul),
    .vlen                    (vlen),
    .acc_en                  (acc_en),
    .acc_out                 (acc_out),
    .busy                    (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (txn %0d, t=%0t)", tag, got, exp, txn_id, $time);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({pfx, "_busy"},      32'(busy), 32'd0);
    check({pfx, "_wb_load"},   32'(wb_load), 32'd0);
    check({pfx, "_acc_en"},    32'(acc_en), 32'd0);
    check({pfx, "_bus_sel"},   32'(bus_sel), 32'd0);
    check({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({pfx, "_rsp_data"},  rsp_payload_outputs_0, 32'd0);
    check({pfx, "_sels"},      32'({reg_op0_sel, reg_op1_sel, reg_wb_sel}), 32'd0);
    check({pfx, "_alu"},       32'({alu_mode, alu_op1_sel, alu_imm}), 32'd0);
    check({pfx, "_vlen"},      32'(vlen), 32'(VLEN_MAX));
    check({pfx, "_vlmul"},     32'(vlmul), 32'd0);
  endtask

  // Issue one command and follow it cycle by cycle. Phase per cycle k after the
  // accepting edge: direct ops (CONFIG/ILLEGAL) are in RSP from k=1; others are
  // READ at k=1, EXEC for n cycles, WB once, then RSP.
  task automatic run_cmd(input logic [9:0] fid, input logic [31:0] in0, input logic [31:0] in1,
                         input logic [7:0] accv, input int rdy_dly, input bit hold_valid);
    int op, n, first_rsp, total, ph, seen, grant;
    bit direct;
    logic [31:0] exp_resp;
    op     = int'(fid[2:0]);
    direct = !(op >= 1 && op <= 3);
    grant  = int'(in0[5:0]);
    if (grant > VLEN_MAX) grant = VLEN_MAX;
    if (op == 0)      exp_resp = 32'(grant);
    else if (direct)  exp_resp = 32'hFFFF_FFFF;
    else if (op == 3) exp_resp = {24'b0, accv};
    else              exp_resp = 32'd0;
    if (op == 1)      n = 1;
    else if (op == 2) n = MUL_LAT;
    else              n = (m_vlen == 0) ? 1 : m_vlen;
    first_rsp = direct ? 1 : n + 3;
    total     = first_rsp + rdy_dly;
    seen      = -1;

    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_payload_function_id = fid;
    cmd_payload_inputs_0    = in0;
    cmd_payload_inputs_1    = in1;
    acc_out   = accv;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    if (op == 0) begin
      m_vlen  = grant;
      m_vlmul = int'(in1[2:0]);
    end

    for (int k = 1; k <= total; k++) begin
      if (k >= first_rsp)  ph = 3;
      else if (k == 1)     ph = 0;
      else if (k <= n + 1) ph = 1;
      else                 ph = 2;
      if (rsp_valid && seen < 0) seen = k;
      check("busy",      32'(busy), 32'd1);
      check("cmd_ready", 32'(cmd_ready), 32'd0);
      check("wb_load",   32'(wb_load), 32'(ph == 2));
      check("acc_en",    32'(acc_en), 32'(ph == 1 && op == 3));
      check("bus_sel",   32'(bus_sel), (ph == 2) ? 32'(op) : 32'd0);
      check("rsp_valid", 32'(rsp_valid), 32'(ph == 3));
      if (ph == 2) check("reg_wb_sel", 32'(reg_wb_sel), 32'(in0[14:10]));
      if (ph < 3) begin
        check("reg_op0_sel", 32'(reg_op0_sel), 32'(in0[4:0]));
        check("reg_op1_sel", 32'(reg_op1_sel), 32'(in0[9:5]));
        check("alu_mode",    32'(alu_mode), 32'(fid[4:3]));
        check("alu_op1_sel", 32'(alu_op1_sel), 32'(fid[5]));
        check("alu_imm",     32'(alu_imm), 32'(in1[7:0]));
      end
      if (ph == 3) check("rsp_data", rsp_payload_outputs_0, exp_resp);
      rsp_ready = (ph == 3) ? (k == total) : 1'($urandom_range(0, 1));
      cmd_valid = (k == total) ? 1'b0 : (hold_valid ? 1'b1 : 1'($urandom_range(0, 1)));
      cmd_payload_function_id = 10'($urandom);
      cmd_payload_inputs_0    = $urandom;
      cmd_payload_inputs_1    = $urandom;
      acc_out = (ph == 3) ? 8'($urandom) : accv;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;

    check("rsp_latency", 32'(seen), 32'(first_rsp));
    check("done_cmd_ready", 32'(cmd_ready), 32'd1);
    check("done_busy",      32'(busy), 32'd0);
    check("done_rsp_valid", 32'(rsp_valid), 32'd0);
    check("vlen",           32'(vlen), 32'(m_vlen));
    check("vlmul",          32'(vlmul), 32'(m_vlmul));
    $display("txn %0d: fid=%h in0=%h op=%0d exec=%0d rdy_dly=%0d resp=%h",
             txn_id, fid, in0, op, direct ? 0 : n, rdy_dly, exp_resp);
    txn_id++;
  endtask

  initial begin
    logic [9:0]  fid;
    logic [31:0] in0, in1;
    int          sel;

    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("por");
    reset = 1'b0;
    @(posedge clk); #1;

    run_cmd(10'h000, 32'd40, 32'd3, 8'h00, 0, 1'b0);       // clamp to 32
    run_cmd(10'h021, 32'h0000_0C41, 32'h0000_00A5, 8'h00, 0, 1'b0);
    run_cmd(10'h002, 32'h0000_1234, 32'h0000_0011, 8'h00, 0, 1'b0);
    run_cmd(10'h000, 32'd4, 32'd1, 8'h00, 0, 1'b0);
    run_cmd(10'h003, 32'h0000_2C22, 32'h0, 8'h5A, 0, 1'b0);
    run_cmd(10'h000, 32'd7, 32'd2, 8'h00, 5, 1'b1);          // held response, cmd_valid high
    run_cmd(10'h006, 32'h0000_7FFF, 32'h0, 8'h00, 2, 1'b0);  // illegal
    run_cmd(10'h000, 32'd0, 32'd0, 8'h00, 0, 1'b0);
    run_cmd(10'h003, 32'h0000_0421, 32'h0, 8'hC3, 1, 1'b0);  // vlen 0 -> one beat

    // Reset in the middle of MUL EXEC.
    cmd_valid = 1'b1;
    cmd_payload_function_id = 10'h002;
    cmd_payload_inputs_0    = 32'h0000_4C63;
    cmd_payload_inputs_1    = 32'h0000_0077;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_exec");
    @(posedge clk); #1;
    reset = 1'b0;
    m_vlen  = VLEN_MAX;
    m_vlmul = 0;
    #1 check("post_rst_ready", 32'(cmd_ready), 32'd1);
    run_cmd(10'h000, 32'd40, 32'd3, 8'h00, 0, 1'b0);

    // Reset while a response is pending.
    cmd_valid = 1'b1;
    cmd_payload_function_id = 10'h000;
    cmd_payload_inputs_0    = 32'd9;
    cmd_payload_inputs_1    = 32'd5;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_rsp");
    @(posedge clk); #1;
    reset = 1'b0;
    m_vlen  = VLEN_MAX;
    m_vlmul = 0;

    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      fid = 10'($urandom);
      if (sel < 2)      fid[2:0] = 3'd0;
      else if (sel < 4) fid[2:0] = 3'd1;
      else if (sel < 6) fid[2:0] = 3'd2;
      else if (sel < 9) fid[2:0] = 3'd3;
      else              fid[2:0] = 3'($urandom_range(4, 7));
      in0 = $urandom;
      in1 = $urandom;
      run_cmd(fid, in0, in1, 8'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vec_ctrl.md
VEC_CTRL -- requirements
Module: vec_ctrl

Interface
REQ-001 Parameter: MUL_LAT, default 2, multiply datapath latency in cycles (1..7).
REQ-002 Parameter: VLEN_MAX, default 32, largest legal vector length.
REQ-003 Port: clk  in  1  sole clock, rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Ports: cmd_valid in 1, cmd_ready out 1, cmd_payload_function_id in 10, cmd_payload_inputs_0 in 32, cmd_payload_inputs_1 in 32, the CPU command channel.
REQ-006 Ports: rsp_valid out 1, rsp_ready in 1, rsp_payload_outputs_0 out 32, the CPU response channel.
REQ-007 Ports: reg_op0_sel out 5, reg_op1_sel out 5, reg_wb_sel out 5, wb_load out 1, the register-file control.
REQ-008 Ports: bus_sel out 2 (00 none, 01 alu, 10 mul, 11 acc), alu_mode out 2, alu_op1_sel out 1, alu_imm out 8, the datapath control.
REQ-009 Ports: vlmul out 3, vlen out 6, acc_en out 1, acc_out in 8, busy out 1.

Function
REQ-010 The FSM SHALL have states IDLE, READ, EXEC, WB and RSP.
REQ-011 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a clk edge with cmd_valid&&cmd_ready, and all payload fields are latched then.
REQ-012 Decode: op = function_id[2:0]; 0 CONFIG, 1 ALU, 2 MUL, 3 ACC, others ILLEGAL.
REQ-013 Operand fields: src0 = inputs_0[4:0], src1 = inputs_0[9:5], dst = inputs_0[14:10], imm = inputs_1[7:0], alu_mode = function_id[4:3], alu_op1_sel = function_id[5].
REQ-014 CONFIG: IDLE->RSP; vlen <= min(inputs_0[5:0], VLEN_MAX); vlmul <= inputs_1[2:0]; response = granted vlen, zero-extended.
REQ-015 ALU/MUL/ACC: IDLE->READ (1 cycle, op sels driven)->EXEC->WB (1 cycle)->RSP.
REQ-016 EXEC lasts 1 cycle for ALU, MUL_LAT cycles for MUL, and vlen cycles for ACC (at least 1 cycle when vlen=0); a down-counter loaded on READ->EXEC times it.
REQ-017 acc_en SHALL be 1 on every ACC EXEC cycle and 0 otherwise.
REQ-018 During WB: wb_load=1, reg_wb_sel=dst, bus_sel = 01/10/11 for ALU/MUL/ACC; outside WB: wb_load=0, bus_sel=00.
REQ-019 reg_op0_sel/reg_op1_sel/alu_mode/alu_op1_sel/alu_imm SHALL hold the latched values from READ through WB.
REQ-020 Response value: ALU/MUL = 0; ACC = {24'b0, acc_out} sampled in WB; ILLEGAL = 32'hFFFFFFFF with no writeback (IDLE->RSP).
REQ-021 In RSP, rsp_valid=1 and rsp_payload_outputs_0 stays stable until rsp_ready; RSP->IDLE on rsp_valid&&rsp_ready.
REQ-022 If rsp_ready is already high on entry to RSP, the response completes in that same cycle, and the next command can be accepted one cycle later.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 cmd_valid asserted outside IDLE SHALL be ignored and SHALL NOT be queued.

Reset
REQ-025 On reset assertion, regardless of state (including mid-EXEC or mid-RSP): state=IDLE, wb_load=0, acc_en=0, bus_sel=00, rsp_valid=0, rsp_payload_outputs_0=0, all sels/alu fields=0, vlen=VLEN_MAX, vlmul=0, counter=0, busy=0.
REQ-026 A pending response SHALL be discarded by reset, and cmd_ready=1 on the first cycle after release.

Structure
REQ-027 A shared package vec_pkg SHALL hold the op-code enum, state enum, bus_sel encodings and the VLEN_MAX default.
REQ-028 The EXEC timing counter SHALL be a sub-module vec_beat_counter (load, decrement, done flag).
REQ-029 The block SHALL contain no datapath arithmetic beyond the vlen clamp compare.

Verification
REQ-030 CONFIG with inputs_0=40, inputs_1=3 -> response 32 after 1 cycle in RSP; vlen=32; vlmul=3.
REQ-031 ALU with function_id=0x21 (alu_mode=0, imm select), inputs_0=0x0C41 -> one WB cycle with wb_load=1, reg_wb_sel=3, bus_sel=01; alu_op1_sel=1; response 0.
REQ-032 MUL with MUL_LAT=3 -> exactly 3 EXEC cycles, then WB with bus_sel=10; accept-to-rsp_valid = 6 cycles.
REQ-033 ACC with vlen=4, acc_out=0x5A -> acc_en high for 4 cycles; response 0x0000005A.
REQ-034 rsp_ready held low 5 cycles -> rsp_valid and payload stable, cmd_ready=0 with cmd_valid=1, and no second command is accepted.
REQ-035 Reset pulse mid-MUL-EXEC -> outputs at their reset values immediately; after release, a CONFIG command completes normally.
